ring_force_rx_unpack: RTL and testbench

// - Receive end of the force-writeback ring protocol, one instance per ring node.
// - Takes packet_t from the local ring stop and consumes only packets whose dest_id == NODE_ID.
// - Buffers them in an in-order FIFO and presents force_rx_t {particle_id, fx, fy, fz} to the

---
 rtl/md_pkg.sv | 44 ++++
 rtl/rx_sync_fifo.sv | 64 ++++++
 rtl/ring_force_rx_unpack.sv | 149 ++++++++++++++
 tb/tb_ring_force_rx_unpack.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types for the force-writeback ring: ring packet, receive-side force record,
// and the receive drain-FSM state encoding.
package md_pkg;

    localparam int NUM_CELLS         = 64;
    localparam int DATA_WIDTH        = 32;
    localparam int PARTICLE_ID_WIDTH = 7;
    localparam int NODE_ID_WIDTH     = $clog2(NUM_CELLS);

    // Packet as it travels on the ring; valid qualifies the whole word.
    typedef struct packed {
        logic                          valid;
        logic [NODE_ID_WIDTH-1:0]      dest_id;
        logic [PARTICLE_ID_WIDTH-1:0]  particle_id;
        logic signed [DATA_WIDTH-1:0]  fx;
        logic signed [DATA_WIDTH-1:0]  fy;
        logic signed [DATA_WIDTH-1:0]  fz;
    } packet_t;

    // Force record delivered to the home-cell force cache.
    typedef struct packed {
        logic [PARTICLE_ID_WIDTH-1:0]  particle_id;
        logic signed [DATA_WIDTH-1:0]  fx;
        logic signed [DATA_WIDTH-1:0]  fy;
        logic signed [DATA_WIDTH-1:0]  fz;
    } force_rx_t;

    typedef enum logic [1:0] {
        RX_RUN   = 2'd0,
        RX_DRAIN = 2'd1,
        RX_DONE  = 2'd2
    } rx_state_t;

    // Strip the routing fields; payload is copied bit for bit.
    function automatic force_rx_t pkt_to_force(input packet_t p);
        force_rx_t f;
        f.particle_id = p.particle_id;
        f.fx          = p.fx;
        f.fy          = p.fy;
        f.fz          = p.fz;
        return f;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// In-order receive buffer. Level is kept as its own counter so full and empty are
// never ambiguous; pointers wrap naturally because DEPTH is a power of two.
// Storage is not reset: an entry is only ever observable while level says it is live,
// and the head output is forced to zero when empty.
module rx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Payload write; data path carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ring_force_rx_unpack.sv
// Receive end of the force-writeback ring for one node: accepts packets addressed to
// NODE_ID, buffers them in order, hands them to the force cache over valid/ready, and
// reports quiescence through a drain_req/drain_done handshake.
// Optional build macro RX_STATS_EN adds stat_pkts / stat_stalls counters.
module ring_force_rx_unpack
    import md_pkg::*;
#(
    parameter logic [NODE_ID_WIDTH-1:0] NODE_ID      = '0,
    parameter int                       FIFO_DEPTH   = 8,
    parameter int                       QUIET_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  packet_t                       pkt_in,
    output logic                          rx_ready,
    output force_rx_t                     wb_out,
    output logic                          wb_out_valid,
    input  logic                          wb_out_ready,
    input  logic                          drain_req,
    output logic                          drain_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef RX_STATS_EN
    ,
    output logic [31:0]                   stat_pkts,
    output logic [31:0]                   stat_stalls
`endif
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);
    localparam logic [QW-1:0] QUIET_MAX  = QW'(QUIET_CYCLES);

    logic       match;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    force_rx_t  push_rec;
    force_rx_t  head_rec;

    rx_state_t       state;
    rx_state_t       state_next;
    logic [QW-1:0]   quiet_cnt;
    logic [QW-1:0]   quiet_cnt_next;
    logic            drain_done_next;

    assign match        = pkt_in.valid && (pkt_in.dest_id == NODE_ID);
    assign rx_ready     = !fifo_full;
    assign push         = match && rx_ready;
    assign wb_out_valid = !fifo_empty;
    assign pop          = wb_out_valid && wb_out_ready;
    assign push_rec     = pkt_to_force(pkt_in);
    assign wb_out       = head_rec;

    rx_sync_fifo #(
        .WIDTH ($bits(force_rx_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .head_data (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Drain FSM state, quiet counter and registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_RUN;
            quiet_cnt  <= '0;
            drain_done <= 1'b0;
        end else begin
            state      <= state_next;
            quiet_cnt  <= quiet_cnt_next;
            drain_done <= drain_done_next;
        end
    end

    // Next state: count idle cycles in DRAIN, fire once on reaching QUIET_CYCLES.
    always_comb begin
        state_next      = state;
        quiet_cnt_next  = quiet_cnt;
        drain_done_next = 1'b0;
        case (state)
            RX_RUN: begin
                if (drain_req) begin
                    state_next     = RX_DRAIN;
                    quiet_cnt_next = '0;
                end
            end
            RX_DRAIN: begin
                if (!drain_req) begin
                    state_next     = RX_RUN;
                    quiet_cnt_next = '0;
                end else if (match || !fifo_empty) begin
                    quiet_cnt_next = '0;
                end else if (quiet_cnt >= QUIET_LAST) begin
                    quiet_cnt_next  = QUIET_MAX;
                    drain_done_next = 1'b1;
                    state_next      = RX_DONE;
                end else begin
                    quiet_cnt_next = quiet_cnt + QW'(1);
                end
            end
            RX_DONE: begin
                if (!drain_req) begin
                    state_next     = RX_RUN;
                    quiet_cnt_next = '0;
                end
            end
            default: begin
                state_next     = RX_RUN;
                quiet_cnt_next = '0;
            end
        endcase
    end

`ifdef RX_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic stats_clear;
    assign stats_clear = (state == RX_RUN) && drain_req;

    // Push and stall counters; cleared when a drain begins, saturating otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts   <= '0;
            stat_stalls <= '0;
        end else if (stats_clear) begin
            stat_pkts   <= '0;
            stat_stalls <= '0;
        end else begin
            if (push) begin
                stat_pkts <= sat_inc(stat_pkts);
            end
            if (match && !rx_ready) begin
                stat_stalls <= sat_inc(stat_stalls);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ring_force_rx_unpack.sv
// Directed bench for ring_force_rx_unpack (NODE_ID=5, FIFO_DEPTH=8, QUIET_CYCLES=4).
module tb_ring_force_rx_unpack;
    import md_pkg::*;

    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    packet_t          pkt_in;
    logic             rx_ready;
    force_rx_t        wb_out;
    logic             wb_out_valid;
    logic             wb_out_ready;
    logic             drain_req;
    logic             drain_done;
    logic [LVL_W-1:0] fifo_level;
`ifdef RX_STATS_EN
    logic [31:0]      stat_pkts;
    logic [31:0]      stat_stalls;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ring_force_rx_unpack #(
        .NODE_ID      (6'd5),
        .FIFO_DEPTH   (DEPTH),
        .QUIET_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pkt_in       (pkt_in),
        .rx_ready     (rx_ready),
        .wb_out       (wb_out),
        .wb_out_valid (wb_out_valid),
        .wb_out_ready (wb_out_ready),
        .drain_req    (drain_req),
        .drain_done   (drain_done),
        .fifo_level   (fifo_level)
`ifdef RX_STATS_EN
        ,
        .stat_pkts    (stat_pkts),
        .stat_stalls  (stat_stalls)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic force_rx_t exp_force(input int pid);
        force_rx_t f;
        f.particle_id = 7'(pid);
        f.fx          = 32'h00A5_0000 | 32'(pid);
        f.fy          = 32'hFFFF_FF00 | 32'(pid);
        f.fz          = 32'h8000_0000 ^ (32'(pid) << 8);
        return f;
    endfunction

    function automatic packet_t mk_pkt(input logic [5:0] dest, input int pid);
        force_rx_t f;
        packet_t   p;
        f             = exp_force(pid);
        p.valid       = 1'b1;
        p.dest_id     = dest;
        p.particle_id = f.particle_id;
        p.fx          = f.fx;
        p.fy          = f.fy;
        p.fz          = f.fz;
        return p;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; pkt_in = '0; wb_out_ready = 1'b0; drain_req = 1'b0;
        #2;
        vectors++; if (wb_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", wb_out_valid); end
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL rst_level got %0d want 0", fifo_level); end
        vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_rx_ready got %b want 1", rx_ready); end
        vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", drain_done); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        vectors++; if (wb_out !== '0) begin miscompares++; $display("FAIL rst_wb_out got %h want 0", wb_out); end
`ifdef RX_STATS_EN
        vectors++; if (stat_pkts !== 32'd0 || stat_stalls !== 32'd0) begin miscompares++; $display("FAIL rst_stats got %0d/%0d want 0/0", stat_pkts, stat_stalls); end
`endif
    endtask

    task automatic test_filter();
        wb_out_ready = 1'b1;
        pkt_in = mk_pkt(6'd4, 3);
        tick();
        vectors++; if (wb_out_valid !== 1'b0) begin miscompares++; $display("FAIL filter_dest4 valid got %b want 0", wb_out_valid); end
        pkt_in = mk_pkt(6'd5, 3);
        tick();
        vectors++; if (wb_out_valid !== 1'b1) begin miscompares++; $display("FAIL filter_dest5 valid got %b want 1", wb_out_valid); end
        vectors++; if (wb_out !== exp_force(3)) begin miscompares++; $display("FAIL filter_dest5 data got %h want %h", wb_out, exp_force(3)); end
        pkt_in = mk_pkt(6'd6, 3);
        tick();
        vectors++; if (wb_out_valid !== 1'b0 || fifo_level !== '0) begin miscompares++; $display("FAIL filter_dest6 valid/level got %b/%0d want 0/0", wb_out_valid, fifo_level); end
        pkt_in = '0;
        tick();
    endtask

    task automatic test_backpressure();
        int  in_idx;
        int  out_idx;
        logic took;
        // Brief drain entry clears the statistics before the counted run.
        drain_req = 1'b1; tick(); drain_req = 1'b0; tick();
        wb_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pkt_in = mk_pkt(6'd5, i);
            vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_%0d got %b want 1", i, rx_ready); end
            tick();
        end
        pkt_in = mk_pkt(6'd5, 8);
        vectors++; if (rx_ready !== 1'b0 || fifo_level !== LVL_W'(8)) begin miscompares++; $display("FAIL bp_full got ready=%b level=%0d want 0/8", rx_ready, fifo_level); end
        for (int h = 0; h < 3; h++) begin
            tick();
            vectors++; if (rx_ready !== 1'b0 || wb_out !== exp_force(0)) begin miscompares++; $display("FAIL bp_hold_%0d got ready=%b head=%h want 0/%h", h, rx_ready, wb_out, exp_force(0)); end
        end
        wb_out_ready = 1'b1;
        in_idx = 8; out_idx = 0;
        for (int cyc = 0; cyc < 40 && out_idx < 10; cyc++) begin
            took = rx_ready && pkt_in.valid;
            if (wb_out_valid) begin
                vectors++; if (wb_out !== exp_force(out_idx)) begin miscompares++; $display("FAIL bp_order_%0d got %h want %h", out_idx, wb_out, exp_force(out_idx)); end
                out_idx++;
            end
            tick();
            if (took) in_idx++;
            pkt_in = (in_idx < 10) ? mk_pkt(6'd5, in_idx) : '0;
        end
        vectors++; if (out_idx != 10) begin miscompares++; $display("FAIL bp_count got %0d want 10", out_idx); end
        vectors++; if (wb_out_valid !== 1'b0 || fifo_level !== '0) begin miscompares++; $display("FAIL bp_empty got valid=%b level=%0d want 0/0", wb_out_valid, fifo_level); end
`ifdef RX_STATS_EN
        vectors++; if (stat_pkts !== 32'd10) begin miscompares++; $display("FAIL bp_stat_pkts got %0d want 10", stat_pkts); end
        vectors++; if (stat_stalls !== 32'd4) begin miscompares++; $display("FAIL bp_stat_stalls got %0d want 4", stat_stalls); end
`endif
        pkt_in = '0;
    endtask

    task automatic test_simultaneous();
        wb_out_ready = 1'b0;
        for (int i = 20; i < 23; i++) begin pkt_in = mk_pkt(6'd5, i); tick(); end
        pkt_in = '0;
        vectors++; if (fifo_level !== LVL_W'(3)) begin miscompares++; $display("FAIL sim_level3 got %0d want 3", fifo_level); end
        pkt_in = mk_pkt(6'd5, 23); wb_out_ready = 1'b1;
        tick();
        vectors++; if (fifo_level !== LVL_W'(3)) begin miscompares++; $display("FAIL sim_pushpop_level got %0d want 3", fifo_level); end
        vectors++; if (wb_out !== exp_force(21)) begin miscompares++; $display("FAIL sim_pushpop_head got %h want %h", wb_out, exp_force(21)); end
        wb_out_ready = 1'b0;
        for (int i = 24; i < 29; i++) begin pkt_in = mk_pkt(6'd5, i); tick(); end
        vectors++; if (rx_ready !== 1'b0 || fifo_level !== LVL_W'(8)) begin miscompares++; $display("FAIL sim_full got ready=%b level=%0d want 0/8", rx_ready, fifo_level); end
        pkt_in = mk_pkt(6'd5, 29); wb_out_ready = 1'b1;
        tick();
        pkt_in = '0;
        vectors++; if (fifo_level !== LVL_W'(7)) begin miscompares++; $display("FAIL sim_full_pop_level got %0d want 7", fifo_level); end
        for (int k = 0; k < 7; k++) begin
            vectors++; if (wb_out_valid !== 1'b1 || wb_out !== exp_force(22 + k)) begin miscompares++; $display("FAIL sim_order_%0d got v=%b %h want 1 %h", k, wb_out_valid, wb_out, exp_force(22 + k)); end
            tick();
        end
        vectors++; if (wb_out_valid !== 1'b0) begin miscompares++; $display("FAIL sim_no_extra got valid=%b want 0", wb_out_valid); end
    endtask

    task automatic test_drain();
        wb_out_ready = 1'b0;
        pkt_in = mk_pkt(6'd5, 40); tick();
        pkt_in = mk_pkt(6'd5, 41); tick();
        pkt_in = '0;
        drain_req = 1'b1; wb_out_ready = 1'b1;
        tick();
`ifdef RX_STATS_EN
        vectors++; if (stat_pkts !== 32'd0 || stat_stalls !== 32'd0) begin miscompares++; $display("FAIL drain_stats_clear got %0d/%0d want 0/0", stat_pkts, stat_stalls); end
`endif
        vectors++; if (fifo_level !== LVL_W'(1)) begin miscompares++; $display("FAIL drain_level1 got %0d want 1", fifo_level); end
        tick();
        vectors++; if (fifo_level !== '0 || drain_done !== 1'b0) begin miscompares++; $display("FAIL drain_emptied got level=%0d done=%b want 0/0", fifo_level, drain_done); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++; if (drain_done !== (k == 4)) begin miscompares++; $display("FAIL drain_pulse_k%0d got %b want %b", k, drain_done, (k == 4)); end
        end
        drain_req = 1'b0; tick();
        // A matching packet mid-count restarts the quiet window.
        drain_req = 1'b1; tick();
        tick(); tick();
        vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL drain_early got %b want 0", drain_done); end
        pkt_in = mk_pkt(6'd5, 50); tick();
        pkt_in = '0;
        vectors++; if (wb_out !== exp_force(50)) begin miscompares++; $display("FAIL drain_match_data got %h want %h", wb_out, exp_force(50)); end
        tick();
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL drain_match_pop got %0d want 0", fifo_level); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++; if (drain_done !== (k == 4)) begin miscompares++; $display("FAIL drain_restart_k%0d got %b want %b", k, drain_done, (k == 4)); end
        end
        drain_req = 1'b0; tick();
        // Abandoned drain: no pulse.
        drain_req = 1'b1; tick(); tick(); tick();
        drain_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL drain_abort_k%0d got %b want 0", k, drain_done); end
        end
    endtask

    task automatic test_reset_mid();
        wb_out_ready = 1'b0;
        for (int i = 60; i < 63; i++) begin pkt_in = mk_pkt(6'd5, i); tick(); end
        vectors++; if (fifo_level !== LVL_W'(3)) begin miscompares++; $display("FAIL rmid_level got %0d want 3", fifo_level); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (wb_out_valid !== 1'b0 || fifo_level !== '0 || rx_ready !== 1'b1 || drain_done !== 1'b0) begin miscompares++; $display("FAIL rmid_state got v=%b lvl=%0d rdy=%b done=%b want 0/0/1/0", wb_out_valid, fifo_level, rx_ready, drain_done); end
        vectors++; if (wb_out !== '0) begin miscompares++; $display("FAIL rmid_wb_out got %h want 0", wb_out); end
        pkt_in = '0;
        @(negedge clk); rst_n = 1'b1;
        tick();
        vectors++; if (wb_out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_after got valid=%b want 0", wb_out_valid); end
        pkt_in = mk_pkt(6'd5, 70); tick();
        pkt_in = '0;
        vectors++; if (wb_out !== exp_force(70) || fifo_level !== LVL_W'(1)) begin miscompares++; $display("FAIL rmid_fresh got %h lvl=%0d want %h lvl=1", wb_out, fifo_level, exp_force(70)); end
    endtask

    initial begin
        test_reset();
        test_filter();
        test_backpressure();
        test_simultaneous();
        test_drain();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
